// File: rtl/imem_access_ctrl_pkg.sv
// Shared definitions for the instruction-memory access controller, the UART
// programmer and the CPU core: widths, FSM state encoding and mode constants.
package imem_access_ctrl_pkg;

    localparam int unsigned REGISTER_WIDTH       = 4;
    localparam int unsigned MEMORY_ADDRESS_WIDTH = 4;
    localparam int unsigned MEMORY_DEPTH         = 1 << MEMORY_ADDRESS_WIDTH;
    localparam int unsigned WRITE_COUNT_WIDTH    = MEMORY_ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {
        stRUN     = 2'd0,
        stDRAIN   = 2'd1,
        stPROG    = 2'd2,
        stRELEASE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_PROG = 1'b1
    } mode_e;

    // CPU/programmer control outputs, registered together with the state
    typedef struct packed {
        logic  halt;
        logic  cpu_reset;
        mode_e mode;
    } ctl_t;

    // Values driven while reset_i is asserted: CPU held in reset, not halted
    localparam ctl_t CTL_RESET = '{halt: 1'b0, cpu_reset: 1'b1, mode: MODE_RUN};

    function automatic ctl_t ctl_for(input state_e s);
        ctl_t c;
        c = '{halt: 1'b0, cpu_reset: 1'b0, mode: MODE_RUN};
        unique case (s)
            stRUN:     c = '{halt: 1'b0, cpu_reset: 1'b0, mode: MODE_RUN};
            stDRAIN:   c = '{halt: 1'b1, cpu_reset: 1'b0, mode: MODE_RUN};
            stPROG:    c = '{halt: 1'b1, cpu_reset: 1'b0, mode: MODE_PROG};
            stRELEASE: c = '{halt: 1'b1, cpu_reset: 1'b1, mode: MODE_RUN};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imem_access_ctrl_if.sv
// Bundle of the programmer, CPU and memory-side signals around the
// instruction-memory access controller.
interface imem_access_ctrl_if;
    import imem_access_ctrl_pkg::*;

    logic                            prog_req_i;
    logic                            cpu_idle_i;
    logic [MEMORY_ADDRESS_WIDTH-1:0] cpu_addr_i;
    logic [REGISTER_WIDTH-1:0]       prog_data_i;
    logic [MEMORY_ADDRESS_WIDTH-1:0] prog_addr_i;
    logic                            prog_we_i;

    logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o;
    logic [REGISTER_WIDTH-1:0]       mem_data_o;
    logic                            mem_we_o;
    logic                            cpu_halt_o;
    logic                            cpu_reset_o;
    logic                            prog_active_o;
    logic [WRITE_COUNT_WIDTH-1:0]    write_count_o;
    logic                            overflow_o;

    // Surrounding top level: programmer, CPU core and memory
    modport master (
        output prog_req_i, cpu_idle_i, cpu_addr_i, prog_data_i, prog_addr_i, prog_we_i,
        input  mem_addr_o, mem_data_o, mem_we_o, cpu_halt_o, cpu_reset_o,
               prog_active_o, write_count_o, overflow_o
    );

    // Access controller
    modport slave (
        input  prog_req_i, cpu_idle_i, cpu_addr_i, prog_data_i, prog_addr_i, prog_we_i,
        output mem_addr_o, mem_data_o, mem_we_o, cpu_halt_o, cpu_reset_o,
               prog_active_o, write_count_o, overflow_o
    );

endinterface

// File: rtl/imem_access_ctrl_imem_mux.sv
// Stateless address/data/write-enable select in front of the single-port
// instruction memory; the programmer path has zero-cycle latency.
module imem_mux
    import imem_access_ctrl_pkg::*;
(
    input  logic                            sel_prog,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] prog_addr,
    input  logic [REGISTER_WIDTH-1:0]       prog_data,
    input  logic                            prog_we,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr,
    output logic [REGISTER_WIDTH-1:0]       mem_data,
    output logic                            mem_we
);

    always_comb begin
        mem_addr = cpu_addr;
        mem_data = '0;
        mem_we   = 1'b0;
        if (sel_prog) begin
            mem_addr = prog_addr;
            mem_data = prog_data;
            mem_we   = prog_we;
        end
    end

endmodule

// File: rtl/imem_access_ctrl.sv
// Arbitrates the instruction memory between CPU fetch (RUN) and the UART
// programmer (PROGRAM), sequencing halt, drain, programming and CPU release.
module imem_access_ctrl
    import imem_access_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 15,
    parameter int unsigned RESET_CYCLES  = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    imem_access_ctrl_if.slave bus
);

    localparam int unsigned TO_W = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
    localparam int unsigned RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_e                       state_q;
    ctl_t                         ctl_q;
    logic [TO_W-1:0]              to_cnt_q;
    logic [RC_W-1:0]              rst_cnt_q;
    logic [WRITE_COUNT_WIDTH-1:0] wr_cnt_q;
    logic                         ovf_q;

    logic drain_expired;
    logic release_done;
    logic wr_full;
    logic sel_prog;
    logic mux_we;

    // drain_expired fires on the DRAIN_TIMEOUT-th cycle spent in stDRAIN
    assign drain_expired = (to_cnt_q + TO_W'(1)) == TO_W'(DRAIN_TIMEOUT);
    assign release_done  = rst_cnt_q == RC_W'(RESET_CYCLES - 1);
    assign wr_full       = wr_cnt_q == WRITE_COUNT_WIDTH'(MEMORY_DEPTH);
    assign sel_prog      = ctl_q.mode == MODE_PROG;

    // Mode FSM and session counters; control outputs change only on transitions
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= stRELEASE;
            ctl_q     <= CTL_RESET;
            to_cnt_q  <= '0;
            rst_cnt_q <= '0;
            wr_cnt_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            unique case (state_q)
                stRUN: begin
                    if (bus.prog_req_i) begin
                        state_q  <= stDRAIN;
                        ctl_q    <= ctl_for(stDRAIN);
                        to_cnt_q <= '0;
                    end
                end
                stDRAIN: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (bus.cpu_idle_i || drain_expired) begin
                        state_q  <= stPROG;
                        ctl_q    <= ctl_for(stPROG);
                        wr_cnt_q <= '0;
                        ovf_q    <= 1'b0;
                    end else if (!bus.prog_req_i) begin
                        state_q <= stRUN;
                        ctl_q   <= ctl_for(stRUN);
                    end
                end
                stPROG: begin
                    if (bus.prog_we_i) begin
                        if (wr_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + WRITE_COUNT_WIDTH'(1);
                        end
                    end
                    if (!bus.prog_req_i) begin
                        state_q   <= stRELEASE;
                        ctl_q     <= ctl_for(stRELEASE);
                        rst_cnt_q <= '0;
                    end
                end
                stRELEASE: begin
                    if (release_done) begin
                        state_q <= stRUN;
                        ctl_q   <= ctl_for(stRUN);
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RC_W'(1);
                    end
                end
            endcase
        end
    end

    imem_mux u_imem_mux (
        .sel_prog  (sel_prog),
        .cpu_addr  (bus.cpu_addr_i),
        .prog_addr (bus.prog_addr_i),
        .prog_data (bus.prog_data_i),
        .prog_we   (bus.prog_we_i),
        .mem_addr  (bus.mem_addr_o),
        .mem_data  (bus.mem_data_o),
        .mem_we    (mux_we)
    );

    // Reset kills an in-flight write without waiting for the state flops
    assign bus.mem_we_o      = mux_we & ~reset_i;
    assign bus.cpu_halt_o    = ctl_q.halt;
    assign bus.cpu_reset_o   = ctl_q.cpu_reset;
    assign bus.prog_active_o = sel_prog;
    assign bus.write_count_o = wr_cnt_q;
    assign bus.overflow_o    = ovf_q;

endmodule
